// File: rtl/gf571_pkg.sv
// Shared constants and types for the GF(2^571) multiplier front end.
package gf571_pkg;

   // Field width and reduction polynomial f(x) = x^571 + x^10 + x^5 + x^2 + 1
   localparam int unsigned M = 571;
   localparam logic [M-1:0] POLY_LOW = (M'(1) << 10) | (M'(1) << 5) | (M'(1) << 2) | M'(1);

   // Multiplier latency in clock edges from operand apply to product valid
   localparam int unsigned MULT_LAT = 4;
   localparam int unsigned NREQ_MAX = 8;

   // One tag pipe stage: valid flag plus requester id
   typedef struct packed {
      logic       vld;
      logic [2:0] id;
   } tag_t;

   // Requester ids
   localparam logic [2:0] REQ_DBL   = 3'd0;
   localparam logic [2:0] REQ_ADD   = 3'd1;
   localparam logic [2:0] REQ_AFF   = 3'd2;
   localparam logic [2:0] REQ_SPARE = 3'd3;

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first active request at or
// above ptr_i, wrapping from N-1 back to 0. The pointer lives in the parent.
module rr_arbiter_n #(
   parameter int unsigned N    = 4,
   parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] gnt_idx_o
);

   logic        found;
   int unsigned pos;

   // Rotating priority search; first hit wins, later hits are masked by found
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      pos       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (32'(ptr_i) + k) % N;
         if (!found && req_i[IdxW'(pos)]) begin
            found                 = 1'b1;
            gnt_o[IdxW'(pos)]     = 1'b1;
            gnt_idx_o             = IdxW'(pos);
         end
      end
   end

endmodule

// File: rtl/gf2m_mult_arbiter_571.sv
// Shares one pipelined GF(2^571) multiplier between NREQ requesters.
// Round-robin issue of one operand pair per clock; a tag pipe matched to the
// multiplier latency steers each product back as a one-cycle response pulse.
module gf2m_mult_arbiter_571
   import gf571_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*M-1:0] req_a,
   input  logic [NREQ*M-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [M-1:0]      rsp_c,
   output logic [M-1:0]      mul_a,
   output logic [M-1:0]      mul_b,
   input  logic [M-1:0]      mul_c,
   output logic              busy
);

   localparam int unsigned IdxW = $clog2(NREQ);

   logic [NREQ-1:0]   gnt;
   logic [IdxW-1:0]   gnt_idx;
   logic              gnt_vld;
   logic [IdxW-1:0]   ptr_q, ptr_d;
   logic [M-1:0]      mul_a_q, mul_a_d;
   logic [M-1:0]      mul_b_q, mul_b_d;
   tag_t [MULT_LAT:0] tag_q;
   tag_t              tag_d0;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [M-1:0]      rsp_c_q, rsp_c_d;
   logic [M-1:0]      opa [NREQ];
   logic [M-1:0]      opb [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
      assign opa[gi] = req_a[gi*M +: M];
      assign opb[gi] = req_b[gi*M +: M];
   end

   rr_arbiter_n #(
      .N    (NREQ),
      .IdxW (IdxW)
   ) u_rr (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // Issue: grants are masked during reset; a grant loads operands, tags stage 0, advances ptr
   always_comb begin
      req_ready = rst ? gnt : '0;
      gnt_vld   = rst & (|gnt);
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      ptr_d     = ptr_q;
      tag_d0    = '0;
      if (gnt_vld) begin
         mul_a_d    = opa[gnt_idx];
         mul_b_d    = opb[gnt_idx];
         ptr_d      = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
         tag_d0.vld = 1'b1;
         tag_d0.id  = 3'(gnt_idx);
      end
   end

   // Response: capture the product when the oldest tag stage is valid; rsp_c holds otherwise
   always_comb begin
      rsp_valid_d = '0;
      rsp_c_d     = rsp_c_q;
      if (tag_q[MULT_LAT].vld) begin
         rsp_valid_d = NREQ'(1) << tag_q[MULT_LAT].id;
         rsp_c_d     = mul_c;
      end
   end

   // Busy while any registered tag stage carries an in-flight product
   always_comb begin
      busy = 1'b0;
      for (int unsigned k = 0; k <= MULT_LAT; k++) begin
         busy = busy | tag_q[k].vld;
      end
   end

   // State registers; reset also flushes the tag pipe so in-flight products are dropped
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         tag_q       <= '0;
         rsp_valid_q <= '0;
         rsp_c_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         tag_q       <= {tag_q[MULT_LAT-1:0], tag_d0};
         rsp_valid_q <= rsp_valid_d;
         rsp_c_q     <= rsp_c_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_gf2m_mult_arbiter_571.sv
// Bench for gf2m_mult_arbiter_571: a behavioural multiplier model drives mul_c,
// a queue-based scoreboard predicts every output each cycle, and directed
// scenarios pin literal values.
module tb_gf2m_mult_arbiter_571;
   import gf571_pkg::*;

   localparam int NREQ = 4;
   localparam int RLAT = MULT_LAT + 2;
   localparam logic [M-1:0] RED = (M'(1) << 10) | (M'(1) << 5) | (M'(1) << 2) | M'(1);

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*M-1:0] req_a;
   logic [NREQ*M-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [M-1:0]      rsp_c;
   logic [M-1:0]      mul_a;
   logic [M-1:0]      mul_b;
   logic [M-1:0]      mul_c;
   logic              busy;

   gf2m_mult_arbiter_571 #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_c     (rsp_c),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_c     (mul_c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Shift-and-add multiply in GF(2^571)
   function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] acc;
      logic [M-1:0] sh;
      logic         top;
      acc = '0;
      sh  = a;
      for (int i = 0; i < M; i++) begin
         if (b[i] === 1'b1) acc = acc ^ sh;
         top = sh[M-1];
         sh  = sh << 1;
         if (top === 1'b1) sh = sh ^ RED;
      end
      return acc;
   endfunction

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ] === 1'b1) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [M-1:0] rnd_op();
      logic [18*32-1:0] t;
      for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom();
      return t[M-1:0];
   endfunction

   // ---------------- multiplier model: exact MULT_LAT-deep product pipe ----------
   logic [M-1:0] mp [MULT_LAT];
   logic [M-1:0] cur_prod, pa, pb;
   assign mul_c = mp[MULT_LAT-1];

   always @(negedge clk) begin
      if (mul_a !== pa || mul_b !== pb) begin
         pa       = mul_a;
         pb       = mul_b;
         cur_prod = gfmul(mul_a, mul_b);
      end
   end

   always @(posedge clk) begin
      mp[0] <= cur_prod;
      for (int k = 1; k < MULT_LAT; k++) mp[k] <= mp[k-1];
   end

   // ---------------- reference model (scoreboard) ----------------
   typedef struct {
      int           due;
      int           id;
      logic [M-1:0] c;
   } exp_t;

   exp_t            sb[$];
   exp_t            ent;
   int              cyc = 0;
   int              ptr_m = 0;
   int              last_gnt_m = -1;
   int              gm;
   bit              started = 1'b0;
   logic [NREQ-1:0] exp_rsp_v = '0;
   logic [M-1:0]    exp_c = '0;
   logic [M-1:0]    exp_mula = '0;
   logic [M-1:0]    exp_mulb = '0;

   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         sb.delete();
         ptr_m      = 0;
         last_gnt_m = -1;
         exp_rsp_v  = '0;
         exp_c      = '0;
         exp_mula   = '0;
         exp_mulb   = '0;
      end else begin
         exp_rsp_v = '0;
         if (sb.size() != 0 && sb[0].due == cyc + 1) begin
            exp_rsp_v = NREQ'(1) << sb[0].id;
            exp_c     = sb[0].c;
            void'(sb.pop_front());
         end
         gm         = pick(req_valid, ptr_m);
         last_gnt_m = gm;
         if (gm >= 0) begin
            ent.due  = cyc + RLAT;
            ent.id   = gm;
            ent.c    = gfmul(req_a[gm*M +: M], req_b[gm*M +: M]);
            sb.push_back(ent);
            exp_mula = req_a[gm*M +: M];
            exp_mulb = req_b[gm*M +: M];
            ptr_m    = (gm + 1) % NREQ;
         end
      end
      cyc++;
      started = 1'b1;
   end

   // ---------------- directed pins, set by the stimulus process ----------------
   bit              pin_ready_v, pin_rspv_v, pin_rspc_v, pin_busy_v;
   logic [NREQ-1:0] pin_ready, pin_rspv;
   logic [M-1:0]    pin_rspc;
   logic            pin_busy;

   // ---------------- compare process ----------------
   int              n_cmp = 0;
   int              n_fail = 0;
   int              ge;
   logic [NREQ-1:0] exp_ready;

   task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         ge        = pick(req_valid, ptr_m);
         exp_ready = (rst === 1'b1 && ge >= 0) ? NREQ'(1) << ge : '0;
         chk("req_ready", M'(req_ready), M'(exp_ready));
         chk("rsp_valid", M'(rsp_valid), M'(exp_rsp_v));
         chk("rsp_c", rsp_c, exp_c);
         chk("busy", M'(busy), M'(sb.size() != 0));
         chk("mul_a", mul_a, exp_mula);
         chk("mul_b", mul_b, exp_mulb);
         if (pin_ready_v) chk("pin_ready", M'(req_ready), M'(pin_ready));
         if (pin_rspv_v) chk("pin_rsp_valid", M'(rsp_valid), M'(pin_rspv));
         if (pin_rspc_v) begin
            chk("pin_rsp_c", rsp_c, pin_rspc);
            chk("pin_model_c", exp_c, pin_rspc);
         end
         if (pin_busy_v) chk("pin_busy", M'(busy), M'(pin_busy));
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_pins();
      pin_ready_v = 0;
      pin_rspv_v  = 0;
      pin_rspc_v  = 0;
      pin_busy_v  = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clear_pins();
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic pin_rsp(input logic [NREQ-1:0] v, input logic [M-1:0] c);
      pin_rspv_v = 1;
      pin_rspv   = v;
      pin_rspc_v = 1;
      pin_rspc   = c;
   endtask

   initial begin
      clear_pins();
      rst       = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;

      // 1: reset held with all requests pending
      for (int k = 0; k < 3; k++) begin
         pin_ready_v = 1; pin_ready = '0;
         pin_rspv_v  = 1; pin_rspv  = '0;
         pin_busy_v  = 1; pin_busy  = 1'b0;
         step();
      end
      rst = 1'b1;
      pin_ready_v = 1; pin_ready = 4'b0001;
      step();
      idle(8);

      // 2: single issue from req1, x * x^570 = x^10 + x^5 + x^2 + 1
      req_valid = 4'b0010;
      req_a[1*M +: M] = M'(2);
      req_b[1*M +: M] = M'(1) << 570;
      pin_ready_v = 1; pin_ready = 4'b0010;
      step();
      req_valid = '0;
      for (int k = 1; k < RLAT; k++) begin
         pin_busy_v = 1; pin_busy = 1'b1;
         step();
      end
      pin_rsp(4'b0010, M'(12'h425));
      pin_busy_v = 1; pin_busy = 1'b0;
      step();
      idle(8);

      // 3: restart pointer at 0, then all four contend for 8 cycles
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*M +: M] = M'(1);
         req_b[i*M +: M] = M'(32'h10 + i);
      end
      for (int k = 0; k < 14; k++) begin
         req_valid = (k < 8) ? '1 : '0;
         if (k < 8) begin
            pin_ready_v = 1; pin_ready = NREQ'(1) << (k % NREQ);
         end
         if (k >= RLAT) pin_rsp(NREQ'(1) << ((k - RLAT) % NREQ), M'(32'h10 + (k - RLAT) % NREQ));
         step();
      end
      idle(8);

      // 4: req2 alone, granted every cycle
      for (int k = 0; k < 11; k++) begin
         req_valid = (k < 5) ? 4'b0100 : '0;
         if (k < 5) begin
            req_a[2*M +: M] = M'(1);
            req_b[2*M +: M] = M'(k + 1);
            pin_ready_v = 1; pin_ready = 4'b0100;
         end
         if (k >= RLAT) pin_rsp(4'b0100, M'(k - RLAT + 1));
         step();
      end
      idle(8);

      // 5: reset while req3 and req0 products are in flight
      req_valid = 4'b1001;
      req_a[0*M +: M] = M'(5); req_b[0*M +: M] = M'(7);
      req_a[3*M +: M] = M'(9); req_b[3*M +: M] = M'(3);
      pin_ready_v = 1; pin_ready = 4'b1000;
      step();
      req_valid = 4'b0001;
      pin_ready_v = 1; pin_ready = 4'b0001;
      step();
      req_valid = '0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      req_valid = '1;
      pin_ready_v = 1; pin_ready = 4'b0001;
      pin_busy_v  = 1; pin_busy  = 1'b0;
      step();
      req_valid = '0;
      for (int k = 0; k < 5; k++) begin
         pin_rspv_v = 1; pin_rspv = '0;
         step();
      end
      idle(8);

      // 6: req0 re-issues in the very cycle its earlier product returns
      req_valid = 4'b0001;
      req_a[0*M +: M] = M'(8); req_b[0*M +: M] = M'(8);
      pin_ready_v = 1; pin_ready = 4'b0001;
      step();
      idle(RLAT - 1);
      req_valid = 4'b0001;
      req_a[0*M +: M] = M'(1) << 285; req_b[0*M +: M] = M'(1) << 285;
      pin_ready_v = 1; pin_ready = 4'b0001;
      pin_rsp(4'b0001, M'(8'h40));
      step();
      idle(RLAT - 1);
      pin_rsp(4'b0001, M'(1) << 570);
      step();
      idle(4);

      // 7: random traffic obeying the hold-until-accepted rule, with rare resets
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && last_gnt_m != i) begin
               if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
            end else begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_a[i*M +: M] = rnd_op();
               req_b[i*M +: M] = ($urandom_range(0, 3) == 0) ? M'($urandom()) : rnd_op();
            end
         end
         rst = ($urandom_range(0, 199) != 0);
         step();
      end
      rst = 1'b1;
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
